// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM responder.
package dsram_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dsram_state_t;

    localparam int unsigned RD_LAT_MAX = 7;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned LANES      = 4;

endpackage

// File: rtl/dsram_byte_bank.sv
// One byte lane of the data SRAM: synchronous write, combinational read.
module dsram_byte_bank #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dsram_responder.sv
// Single-port data SRAM responder with byte-lane writes and RD_LAT-cycle reads.
// Optional out-of-range detection enabled by defining DSRAM_RANGE_CHK_EN.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    dsram_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           hold_q, hold_d;
    logic                  hold_err_q, hold_err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  accept;
    logic [31:0]           mem_rdata;
    logic [31:0]           read_word;
    logic                  unused_offset;

    assign offset = addr - BASE_ADDR;
    assign idx    = offset[DEPTH_LOG2+1:2];
    assign busy   = (state_q == WAIT);
    assign accept = en & ~busy;

`ifdef DSRAM_RANGE_CHK_EN
    assign in_range = ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
`else
    // Upper offset bits are dropped, so addresses alias modulo the array size.
    assign in_range = 1'b1;
`endif

    assign unused_offset = ^offset;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dsram_byte_bank #(
            .DEPTH_LOG2(DEPTH_LOG2)
        ) u_bank (
            .clk  (clk),
            .we   (accept & wen[g] & in_range),
            .idx  (idx),
            .wdata(wdata[8*g +: 8]),
            .rdata(mem_rdata[8*g +: 8])
        );
    end

    assign read_word = in_range ? mem_rdata : 32'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_err_d = hold_err_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (|wen) begin
                        err_d = ~in_range;
                    end else if (RD_LAT <= 1) begin
                        rdata_d  = read_word;
                        rvalid_d = 1'b1;
                        err_d    = ~in_range;
                    end else begin
                        // Word is captured now so later writes cannot alter this result.
                        state_d    = WAIT;
                        cnt_d      = LAT_LOAD;
                        hold_d     = read_word;
                        hold_err_d = ~in_range;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rdata_d  = hold_q;
                    rvalid_d = 1'b1;
                    err_d    = hold_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_err_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_err_q <= hold_err_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: three instances at RD_LAT 1, 3 and 4.
module tb_dsram_responder;

    logic        clk;
    logic        rst;
    logic        en1, en3, en4;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;

    logic [31:0] rdata1, rdata3, rdata4;
    logic        rvalid1, rvalid3, rvalid4;
    logic        busy1, busy3, busy4;
    logic        err1, err3, err4;

    int n_vec;
    int n_bad;

    dsram_responder #(.DEPTH_LOG2(6), .RD_LAT(1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .err(err1)
    );

    dsram_responder #(.DEPTH_LOG2(6), .RD_LAT(3), .BASE_ADDR(32'h0)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .rvalid(rvalid3), .busy(busy3), .err(err3)
    );

    dsram_responder #(.DEPTH_LOG2(4), .RD_LAT(4), .BASE_ADDR(32'h0)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .rvalid(rvalid4), .busy(busy4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addr  = a;
        wen   = w;
        wdata = d;
    endtask

    initial begin
        logic [31:0] exp_oor_rdata;
        logic [31:0] exp_oor_err;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        en1   = 1'b0;
        en3   = 1'b0;
        en4   = 1'b0;
        req(32'h0, 4'h0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);
        chk("rst_rdata4", rdata4, 32'h0);

        // RD_LAT=1 byte-lane writes
        en1 = 1'b1;
        req(32'h40, 4'b1111, 32'h1122_3344);
        tick();
        chk("w1_rvalid", {31'd0, rvalid1}, 32'd0);
        chk("w1_busy", {31'd0, busy1}, 32'd0);
        chk("w1_rdata_kept", rdata1, 32'h0);
        req(32'h40, 4'b0010, 32'h0000_AA00);
        tick();
        chk("w2_busy", {31'd0, busy1}, 32'd0);
        req(32'h40, 4'b0000, 32'h0);
        tick();
        chk("r1_rvalid", {31'd0, rvalid1}, 32'd1);
        chk("r1_rdata", rdata1, 32'h1122_AA44);
        chk("r1_busy", {31'd0, busy1}, 32'd0);
        en1 = 1'b0;
        tick();
        chk("r1_pulse_end", {31'd0, rvalid1}, 32'd0);
        chk("r1_rdata_hold", rdata1, 32'h1122_AA44);

        // Read-after-write, lanes 0 and 3, ignored low address bits
        en1 = 1'b1;
        req(32'h44, 4'b1111, 32'hDEAD_BEEF);
        tick();
        req(32'h44, 4'b0000, 32'h0);
        tick();
        chk("raw_rdata", rdata1, 32'hDEAD_BEEF);
        chk("raw_rvalid", {31'd0, rvalid1}, 32'd1);
        req(32'h44, 4'b1001, 32'hA500_005A);
        tick();
        req(32'h47, 4'b0000, 32'h0);
        tick();
        chk("lane03_rdata", rdata1, 32'hA5AD_BE5A);
        en1 = 1'b0;
        tick();

        // RD_LAT=3: preload, writes never raise busy
        en3 = 1'b1;
        req(32'h0, 4'b1111, 32'hCAFE_0000);
        tick();
        chk("w3a_busy", {31'd0, busy3}, 32'd0);
        req(32'h4, 4'b1111, 32'h0000_BEEF);
        tick();
        chk("w3b_busy", {31'd0, busy3}, 32'd0);
        req(32'h8, 4'b1111, 32'h8888_8888);
        tick();
        chk("w3c_rvalid", {31'd0, rvalid3}, 32'd0);

        // Back-to-back reads of 0x0 then 0x4
        req(32'h0, 4'b0000, 32'h0);
        tick();
        chk("b2b_e0_busy", {31'd0, busy3}, 32'd1);
        chk("b2b_e0_rvalid", {31'd0, rvalid3}, 32'd0);
        req(32'h4, 4'b0000, 32'h0);
        tick();
        chk("b2b_e1_busy", {31'd0, busy3}, 32'd1);
        tick();
        chk("b2b_e2_rvalid", {31'd0, rvalid3}, 32'd1);
        chk("b2b_e2_rdata", rdata3, 32'hCAFE_0000);
        chk("b2b_e2_busy", {31'd0, busy3}, 32'd0);
        tick();
        en3 = 1'b0;
        chk("b2b_e3_busy", {31'd0, busy3}, 32'd1);
        chk("b2b_e3_rvalid", {31'd0, rvalid3}, 32'd0);
        chk("b2b_e3_rdata", rdata3, 32'hCAFE_0000);
        tick();
        chk("b2b_e4_busy", {31'd0, busy3}, 32'd1);
        tick();
        chk("b2b_e5_rvalid", {31'd0, rvalid3}, 32'd1);
        chk("b2b_e5_rdata", rdata3, 32'h0000_BEEF);
        chk("b2b_e5_busy", {31'd0, busy3}, 32'd0);

        // Write to 0x8 while busy is ignored; read result was captured at acceptance
        en3 = 1'b1;
        req(32'h8, 4'b0000, 32'h0);
        tick();
        req(32'h8, 4'b1111, 32'h1234_5678);
        tick();
        chk("bi_busy", {31'd0, busy3}, 32'd1);
        tick();
        en3 = 1'b0;
        chk("bi_rvalid", {31'd0, rvalid3}, 32'd1);
        chk("bi_rdata", rdata3, 32'h8888_8888);
        en3 = 1'b1;
        req(32'h8, 4'b0000, 32'h0);
        tick();
        en3 = 1'b0;
        tick();
        tick();
        chk("bi_reread", rdata3, 32'h8888_8888);
        chk("bi_reread_valid", {31'd0, rvalid3}, 32'd1);

        // RD_LAT=4, DEPTH_LOG2=4: read 0x40 lies outside the 64-byte array
`ifdef DSRAM_RANGE_CHK_EN
        exp_oor_rdata = 32'h0;
        exp_oor_err   = 32'd1;
`else
        exp_oor_rdata = 32'h600D_F00D;
        exp_oor_err   = 32'd0;
`endif
        en4 = 1'b1;
        req(32'h0, 4'b1111, 32'h600D_F00D);
        tick();
        chk("w4_err", {31'd0, err4}, 32'd0);
        req(32'h40, 4'b0000, 32'h0);
        tick();
        en4 = 1'b0;
        chk("oor_busy0", {31'd0, busy4}, 32'd1);
        tick();
        tick();
        chk("oor_busy2", {31'd0, busy4}, 32'd1);
        chk("oor_norvalid", {31'd0, rvalid4}, 32'd0);
        tick();
        chk("oor_rvalid", {31'd0, rvalid4}, 32'd1);
        chk("oor_rdata", rdata4, exp_oor_rdata);
        chk("oor_err", {31'd0, err4}, exp_oor_err);
        chk("oor_busy_done", {31'd0, busy4}, 32'd0);
        tick();
        chk("oor_err_pulse", {31'd0, err4}, 32'd0);

        // Out-of-range write raises err the cycle after acceptance
        en4 = 1'b1;
        req(32'h44, 4'b1111, 32'h1111_1111);
        tick();
        en4 = 1'b0;
        chk("oorw_err", {31'd0, err4}, exp_oor_err);
        chk("oorw_busy", {31'd0, busy4}, 32'd0);

        // Reset two cycles after a read is accepted aborts it
        en4 = 1'b1;
        req(32'h0, 4'b0000, 32'h0);
        tick();
        en4 = 1'b0;
        tick();
        tick();
        chk("rmr_busy_pre", {31'd0, busy4}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rmr_busy_async", {31'd0, busy4}, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rmr_no_rvalid", {31'd0, rvalid4}, 32'd0);
            chk("rmr_busy", {31'd0, busy4}, 32'd0);
        end
        chk("rmr_rdata", rdata4, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
